// File: rtl/fetch_pc_pipeline_if.sv
// Fetch-stage bus: next-PC / hazard / imem inputs in, PC and IF/ID register outputs back.
interface fetch_pc_pipeline_if #(
   parameter int COUNT_WIDTH = 32
);
   logic [31:0]            pcInput;
   logic                   pcWriteEnable;
   logic                   flush;
   logic [31:0]            instrIn;
   logic [31:0]            pcOut;
   logic [31:0]            pcPlus4;
   logic [31:0]            ifIdPc;
   logic [31:0]            ifIdPcPlus4;
   logic [31:0]            ifIdInstr;
   logic                   ifIdValid;
   logic                   misalignedFault;
   logic [COUNT_WIDTH-1:0] fetchCount;

   modport master (
      output pcInput, pcWriteEnable, flush, instrIn,
      input  pcOut, pcPlus4, ifIdPc, ifIdPcPlus4, ifIdInstr, ifIdValid,
             misalignedFault, fetchCount
   );

   modport slave (
      input  pcInput, pcWriteEnable, flush, instrIn,
      output pcOut, pcPlus4, ifIdPc, ifIdPcPlus4, ifIdInstr, ifIdValid,
             misalignedFault, fetchCount
   );
endinterface

// File: rtl/fetch_pc_pipeline.sv
// Fetch stage: architectural PC, pc+4, IF/ID pipeline register, misaligned-target trap.
//
// state | meaning
// BOOT  | one bubble cycle after reset, PC held at RESET_VECTOR
// RUN   | normal fetch: misalign trap > flush > stall > advance
// FAULT | misaligned target seen; PC, IF/ID (bubble) and count frozen until reset
module fetch_pc_pipeline #(
   parameter logic [31:0] RESET_VECTOR = 32'h0000_0000,
   parameter logic [31:0] NOP_INSTR    = 32'h0000_0013,
   parameter int          COUNT_WIDTH  = 32
) (
   input logic                clk,
   input logic                reset,
   fetch_pc_pipeline_if.slave bus
);

   typedef enum logic [1:0] {
      BOOT  = 2'd0,
      RUN   = 2'd1,
      FAULT = 2'd2
   } state_t;

   state_t                 state;
   state_t                 state_next;
   logic                   pc_load;
   logic                   ifid_load;
   logic                   ifid_bubble;
   logic                   fault_set;
   logic                   misaligned;

   logic [31:0]            pc;
   logic [31:0]            if_id_pc;
   logic [31:0]            if_id_pc_plus4;
   logic [31:0]            if_id_instr;
   logic                   if_id_valid;
   logic                   fault;
   logic [COUNT_WIDTH-1:0] fetch_count;

   assign misaligned = (bus.pcInput[1:0] != 2'b00);

   // State register.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state <= BOOT;
      end else begin
         state <= state_next;
      end
   end

   // Next state and per-edge datapath controls; the trap only applies on edges that load the PC.
   always_comb begin
      state_next  = state;
      pc_load     = 1'b0;
      ifid_load   = 1'b0;
      ifid_bubble = 1'b0;
      fault_set   = 1'b0;
      case (state)
         BOOT: begin
            state_next  = RUN;
            ifid_bubble = 1'b1;
         end
         RUN: begin
            if ((bus.flush || bus.pcWriteEnable) && misaligned) begin
               state_next  = FAULT;
               fault_set   = 1'b1;
               ifid_bubble = 1'b1;
            end else if (bus.flush) begin
               pc_load     = 1'b1;
               ifid_bubble = 1'b1;
            end else if (bus.pcWriteEnable) begin
               pc_load   = 1'b1;
               ifid_load = 1'b1;
            end
         end
         FAULT: begin
            ifid_bubble = 1'b1;
         end
         default: begin
            state_next  = BOOT;
            ifid_bubble = 1'b1;
         end
      endcase
   end

   // PC, IF/ID register, sticky fault flag and fetch counter.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         pc             <= RESET_VECTOR;
         if_id_pc       <= 32'd0;
         if_id_pc_plus4 <= 32'd0;
         if_id_instr    <= NOP_INSTR;
         if_id_valid    <= 1'b0;
         fault          <= 1'b0;
         fetch_count    <= '0;
      end else begin
         if (pc_load) begin
            pc <= bus.pcInput;
         end
         if (fault_set) begin
            fault <= 1'b1;
         end
         if (ifid_load) begin
            if_id_pc       <= pc;
            if_id_pc_plus4 <= bus.pcPlus4;
            if_id_instr    <= bus.instrIn;
            if_id_valid    <= 1'b1;
            fetch_count    <= fetch_count + 1'b1;
         end else if (ifid_bubble) begin
            // Bubble keeps the stale pc/pc+4 so downstream debug still sees the last fetch.
            if_id_instr <= NOP_INSTR;
            if_id_valid <= 1'b0;
         end
      end
   end

   assign bus.pcOut           = pc;
   assign bus.pcPlus4         = pc + 32'd4;
   assign bus.ifIdPc          = if_id_pc;
   assign bus.ifIdPcPlus4     = if_id_pc_plus4;
   assign bus.ifIdInstr       = if_id_instr;
   assign bus.ifIdValid       = if_id_valid;
   assign bus.misalignedFault = fault;
   assign bus.fetchCount      = fetch_count;

endmodule
